// File: rtl/arb2_pkg.sv
// rtl/arb2_pkg.sv - shared types and constants for the two-input round-robin arbiter
//
// Contents:
//   arb_state_e       - arbiter FSM state (IDLE, G0, G1)
//   GRANT_I0/GRANT_I1 - values driven on sel for each grant
package arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam logic GRANT_I0 = 1'b0;
    localparam logic GRANT_I1 = 1'b1;

endpackage

// File: rtl/mux2_w.sv
// rtl/mux2_w.sv - DW-wide 2:1 mux carrying payload plus end-of-packet flag
//
// Ports:
//   sel_i          select: GRANT_I0 picks d0/l0, GRANT_I1 picks d1/l1
//   d0_i, l0_i     stream 0 payload and last flag
//   d1_i, l1_i     stream 1 payload and last flag
//   data_o, last_o selected payload and last flag
module mux2_w
    import arb2_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          sel_i,
    input  logic [DW-1:0] d0_i,
    input  logic          l0_i,
    input  logic [DW-1:0] d1_i,
    input  logic          l1_i,
    output logic [DW-1:0] data_o,
    output logic          last_o
);

    assign data_o = (sel_i == GRANT_I1) ? d1_i : d0_i;
    assign last_o = (sel_i == GRANT_I1) ? l1_i : l0_i;

endmodule

// File: rtl/rr_arb2_stage.sv
// rtl/rr_arb2_stage.sv - two-input round-robin arbiter with 1-entry registered output stage
//
// Optional feature: ARB_PKT_LOCK_EN keeps the grant on one stream until it
// delivers a beat with last=1, so packets are never interleaved.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i0_valid/ready/data/last  stream 0 handshake and payload
//   i1_valid/ready/data/last  stream 1 handshake and payload
//   sel                       registered grant (0 = i0, 1 = i1), drives the 2:1 mux
//   y_valid/ready/data/last   output stage handshake and payload
module rr_arb2_stage
    import arb2_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i0_valid,
    output logic          i0_ready,
    input  logic [DW-1:0] i0_data,
    input  logic          i0_last,
    input  logic          i1_valid,
    output logic          i1_ready,
    input  logic [DW-1:0] i1_data,
    input  logic          i1_last,
    output logic          sel,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [DW-1:0] y_data,
    output logic          y_last
);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          y_valid_q, y_valid_d;
    logic [DW-1:0] y_data_q;
    logic          y_last_q;
    logic          in_pkt_q;
    logic          lock_hold;

    logic          space;
    logic          xfer0, xfer1, xfer;
    logic [DW-1:0] mux_data;
    logic          mux_last;

    // Output register can take a beat if empty or being drained this cycle.
    assign space    = !y_valid_q || y_ready;
    assign i0_ready = (state_q == G0) && space;
    assign i1_ready = (state_q == G1) && space;
    assign xfer0    = i0_valid && i0_ready;
    assign xfer1    = i1_valid && i1_ready;
    assign xfer     = xfer0 || xfer1;

    // sel_q always matches the granted stream in G0/G1, so the mux output is
    // the beat being transferred whenever xfer is high.
    mux2_w #(.DW(DW)) u_mux (
        .sel_i  (sel_q),
        .d0_i   (i0_data),
        .l0_i   (i0_last),
        .d1_i   (i1_data),
        .l1_i   (i1_last),
        .data_o (mux_data),
        .last_o (mux_last)
    );

`ifdef ARB_PKT_LOCK_EN
    logic in_pkt_d;

    // A non-final beat pins the grant to its stream until the packet ends.
    assign lock_hold = !mux_last;
    assign in_pkt_d  = xfer ? !mux_last : in_pkt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end
`else
    assign lock_hold = 1'b0;
    assign in_pkt_q  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // i0 wins a tie on the first arbitration.
                if (i0_valid) begin
                    state_d = G0;
                end else if (i1_valid) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (xfer0) begin
                    if (!lock_hold && i1_valid) begin
                        state_d = G1;
                    end
                end else if (!i0_valid && i1_valid && !in_pkt_q) begin
                    state_d = G1;
                end
            end
            G1: begin
                if (xfer1) begin
                    if (!lock_hold && i0_valid) begin
                        state_d = G0;
                    end
                end else if (!i1_valid && i0_valid && !in_pkt_q) begin
                    state_d = G0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel is registered from the next state so it lines up with state_q;
    // it keeps its last value while the FSM sits in IDLE.
    always_comb begin
        sel_d = sel_q;
        if (state_d == G0) begin
            sel_d = GRANT_I0;
        end else if (state_d == G1) begin
            sel_d = GRANT_I1;
        end
    end

    // A load in the same cycle as a drain keeps y_valid high with new data.
    always_comb begin
        y_valid_d = y_valid_q;
        if (xfer) begin
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= GRANT_I0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            y_valid_q <= y_valid_d;
            if (xfer) begin
                y_data_q <= mux_data;
                y_last_q <= mux_last;
            end
        end
    end

    assign sel     = sel_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;

endmodule

// File: tb/tb_rr_arb2_stage.sv
// tb/tb_rr_arb2_stage.sv - directed scoreboard bench for rr_arb2_stage
module tb_rr_arb2_stage;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i0_valid, i0_ready, i0_last;
    logic [DW-1:0] i0_data;
    logic          i1_valid, i1_ready, i1_last;
    logic [DW-1:0] i1_data;
    logic          sel;
    logic          y_valid, y_ready, y_last;
    logic [DW-1:0] y_data;

    always #5 clk = ~clk;

    rr_arb2_stage #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i0_data  (i0_data),
        .i0_last  (i0_last),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .i1_data  (i1_data),
        .i1_last  (i1_last),
        .sel      (sel),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .y_last   (y_last)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Entries are {last, data}.
    logic [DW:0] exp_q[$];
    logic [DW:0] src0[$];
    logic [DW:0] src1[$];

    bit hold_chk   = 1'b0;
    bit ss_chk     = 1'b0;
    bit seen_first = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        i0_valid = (src0.size() > 0);
        if (src0.size() > 0) begin
            i0_data = src0[0][DW-1:0];
            i0_last = src0[0][DW];
        end else begin
            i0_data = '0;
            i0_last = 1'b0;
        end
        i1_valid = (src1.size() > 0);
        if (src1.size() > 0) begin
            i1_data = src1[0][DW-1:0];
            i1_last = src1[0][DW];
        end else begin
            i1_data = '0;
            i1_last = 1'b0;
        end
    endtask

    // One clock: observe at the falling edge, advance sources after the rising edge.
    task automatic cyc();
        logic a0, a1;
        logic [DW:0] e;
        @(negedge clk);
        a0 = i0_valid && i0_ready;
        a1 = i1_valid && i1_ready;
        if (hold_chk && seen_first && exp_q.size() > 0)
            check("y_valid_hold", y_valid, 1);
        if (ss_chk && y_valid) begin
            check("ss_sel", sel, 1);
            check("ss_i0_ready", i0_ready, 0);
        end
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("y_data", y_data, e[DW-1:0]);
                check("y_last", y_last, e[DW]);
                seen_first = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (a0) void'(src0.pop_front());
        if (a1) void'(src1.pop_front());
        drive();
    endtask

    task automatic run(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < max) begin
            cyc();
            n++;
        end
        check({tag, "_timeout"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        y_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_sel", sel, 0);
        check("rst_i0_ready", i0_ready, 0);
        check("rst_i1_ready", i1_ready, 0);
        check("rst_y_data", y_data, 0);
        check("rst_y_last", y_last, 0);
        rst = 1'b0;

        // Contention: i0 wins first, then strict alternation.
        for (int i = 0; i < 4; i++) begin
            src0.push_back({1'b1, 8'hA0 + 8'(i)});
            src1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 8'hA0 + 8'(i)});
            exp_q.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        drive();
        hold_chk = 1'b1;
        seen_first = 1'b0;
        cyc();
        check("rel_sel", sel, 0);
        check("rel_i0_ready", i0_ready, 1);
        check("rel_i1_ready", i1_ready, 0);
        run("cont", 40);
        check("cont_end_sel", sel, 1);

        // Single stream on i1.
        for (int i = 1; i <= 3; i++) begin
            src1.push_back({1'b1, 8'(i)});
            exp_q.push_back({1'b1, 8'(i)});
        end
        drive();
        seen_first = 1'b0;
        ss_chk = 1'b1;
        run("single", 20);
        ss_chk = 1'b0;
        hold_chk = 1'b0;

        // Backpressure: one beat held, competitor arrives, grant must not move.
        y_ready = 1'b0;
        src0.push_back({1'b1, 8'hC0});
        src0.push_back({1'b1, 8'hC1});
        drive();
        n = 0;
        while (!y_valid && n < 10) begin
            cyc();
            n++;
        end
        check("bp_loaded", y_valid, 1);
        src1.push_back({1'b1, 8'hD0});
        drive();
        exp_q.push_back({1'b1, 8'hC0});
        exp_q.push_back({1'b1, 8'hC1});
        exp_q.push_back({1'b1, 8'hD0});
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_i0_ready", i0_ready, 0);
            check("bp_i1_ready", i1_ready, 0);
            check("bp_sel", sel, 0);
            check("bp_y_valid", y_valid, 1);
            check("bp_y_data", y_data, 8'hC0);
        end
        y_ready = 1'b1;
        run("bp", 20);

        // Packet: i0 takes the grant first, then i1 competes throughout.
        src0.push_back({1'b0, 8'h50});
        src0.push_back({1'b0, 8'h51});
        src0.push_back({1'b1, 8'h52});
        drive();
        cyc();
        check("pkt_start_sel", sel, 0);
        for (int i = 0; i < 3; i++) src1.push_back({1'b1, 8'h60 + 8'(i)});
        drive();
`ifdef ARB_PKT_LOCK_EN
        exp_q.push_back({1'b0, 8'h50});
        exp_q.push_back({1'b0, 8'h51});
        exp_q.push_back({1'b1, 8'h52});
        exp_q.push_back({1'b1, 8'h60});
        exp_q.push_back({1'b1, 8'h61});
        exp_q.push_back({1'b1, 8'h62});
`else
        exp_q.push_back({1'b0, 8'h50});
        exp_q.push_back({1'b1, 8'h60});
        exp_q.push_back({1'b0, 8'h51});
        exp_q.push_back({1'b1, 8'h61});
        exp_q.push_back({1'b1, 8'h52});
        exp_q.push_back({1'b1, 8'h62});
`endif
        run("pkt", 30);

        // Asynchronous reset while a beat is held on i1's grant.
        y_ready = 1'b0;
        src1.push_back({1'b1, 8'h70});
        drive();
        n = 0;
        while (!y_valid && n < 10) begin
            cyc();
            n++;
        end
        check("pre_rst_y_valid", y_valid, 1);
        check("pre_rst_sel", sel, 1);
        y_ready = 1'b1;
        #0;
        check("pre_rst_i1_ready", i1_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_y_valid", y_valid, 0);
        check("arst_sel", sel, 0);
        check("arst_i0_ready", i0_ready, 0);
        check("arst_i1_ready", i1_ready, 0);
        exp_q.delete();
        src0.delete();
        src1.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        src0.push_back({1'b1, 8'h80});
        drive();
        cyc();
        check("post_rst_sel", sel, 0);
        check("post_rst_i0_ready", i0_ready, 1);
        check("post_rst_no_replay", y_valid, 0);
        exp_q.push_back({1'b1, 8'h80});
        run("post_rst", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
